// File: rtl/compteur_decompteur_source.sv
// Up/down counter feeding the overflow detector: updates a signed 12-bit value, then strobes Count.
// Optional feature macro COMPTEUR_BCD_EN adds a Bcd output produced by a CONVERT state before the strobe.
`timescale 1ns/1ps

module compteur_decompteur_source #(
    parameter int unsigned WRAP       = 0,
    parameter int unsigned STROBE_LEN = 2,
    parameter int unsigned STEP       = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Inc,
    input  logic        Dec,
    input  logic        Load,
    input  logic [11:0] LoadValue,
    output logic [11:0] Compteurs,
    output logic        Count,
    output logic        Busy
`ifdef COMPTEUR_BCD_EN
    ,
    output logic [11:0] Bcd
`endif
);

    localparam int unsigned CW = $clog2(STROBE_LEN + 1);
    localparam logic signed [12:0] STEP13 = 13'(STEP);

`ifdef COMPTEUR_BCD_EN
    typedef enum logic [1:0] {IDLE, UPDATE, CONVERT, STROBE} state_t;
`else
    typedef enum logic [1:0] {IDLE, UPDATE, STROBE} state_t;
`endif

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      inc_sync;
    logic [2:0]      dec_sync;
    logic            inc_p;
    logic            dec_p;
    logic signed [12:0] cur13;
    logic signed [12:0] sum13;
    logic signed [12:0] res13;
    logic [11:0]     next12;

    // Two flops of synchronisation, third flop for rising-edge detection
    assign inc_p = inc_sync[1] & ~inc_sync[2];
    assign dec_p = dec_sync[1] & ~dec_sync[2];

    // Next value: 13-bit signed intermediate, then fold (WRAP) or clamp
    always_comb begin
        cur13 = signed'({Compteurs[11], Compteurs});
        sum13 = inc_p ? (cur13 + STEP13) : (cur13 - STEP13);
        res13 = sum13;
        if (WRAP != 0) begin
            if (sum13 > 13'sd999)
                res13 = sum13 - 13'sd1000;
            else if (sum13 < 13'sd0)
                res13 = sum13 + 13'sd1000;
        end else begin
            if (sum13 > 13'sd2047)
                res13 = 13'sd2047;
            else if (sum13 < -13'sd2048)
                res13 = -13'sd2048;
        end
        next12 = 12'(res13);
    end

`ifdef COMPTEUR_BCD_EN
    logic [23:0] acc;
    logic [23:0] acc_nxt;
    logic [11:0] adj;
    logic [3:0]  bitcnt;
    logic        oor;

    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int d = 0; d < 3; d++) begin
            if (r[d*4 +: 4] >= 4'd5)
                r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // One shift-add-3 step on the {bcd, binary} register
    always_comb begin
        adj     = add3(acc[23:12]);
        acc_nxt = 24'({adj, acc[11:0]} << 1);
    end
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            Compteurs <= '0;
            Count     <= 1'b0;
            Busy      <= 1'b0;
            cnt       <= '0;
            inc_sync  <= '0;
            dec_sync  <= '0;
`ifdef COMPTEUR_BCD_EN
            acc       <= '0;
            bitcnt    <= '0;
            oor       <= 1'b0;
            Bcd       <= 12'h000;
`endif
        end else begin
            inc_sync <= {inc_sync[1:0], Inc};
            dec_sync <= {dec_sync[1:0], Dec};
            case (state)
                IDLE: begin
                    if (Load) begin
                        Compteurs <= LoadValue;
                        Busy      <= 1'b1;
                        state     <= UPDATE;
                    end else if (inc_p ^ dec_p) begin
                        Compteurs <= next12;
                        Busy      <= 1'b1;
                        state     <= UPDATE;
                    end
                end
                UPDATE: begin
`ifdef COMPTEUR_BCD_EN
                    acc    <= {12'h000, Compteurs};
                    oor    <= Compteurs[11] | (Compteurs > 12'd999);
                    bitcnt <= '0;
                    state  <= CONVERT;
`else
                    cnt    <= '0;
                    state  <= STROBE;
`endif
                end
`ifdef COMPTEUR_BCD_EN
                CONVERT: begin
                    acc    <= acc_nxt;
                    bitcnt <= bitcnt + 4'd1;
                    if (bitcnt == 4'd11) begin
                        Bcd   <= oor ? 12'hFFF : acc_nxt[23:12];
                        cnt   <= '0;
                        state <= STROBE;
                    end
                end
`endif
                // First STROBE cycle raises Count; it stays high STROBE_LEN cycles
                STROBE: begin
                    if (cnt == CW'(STROBE_LEN)) begin
                        Count <= 1'b0;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        Count <= 1'b1;
                        cnt   <= cnt + CW'(1);
                    end
                end
                default: begin
                    Count <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compteur_decompteur_source.sv
// Bench for compteur_decompteur_source: a wrapping and a saturating instance share stimulus,
// each checked against an arithmetic reference model of the counter value and strobe timing.
`timescale 1ns/1ps

module tb_compteur_decompteur_source;

    localparam int L = 2;
`ifdef COMPTEUR_BCD_EN
    localparam int CL = 14;
`else
    localparam int CL = 2;
`endif

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Inc;
    logic        Dec;
    logic        Load;
    logic [11:0] LoadValue;
    logic [11:0] cw, cf;
    logic        countw, countf, busyw, busyf;
`ifdef COMPTEUR_BCD_EN
    logic [11:0] bcdw, bcdf;
`endif

    int checks = 0;
    int fails  = 0;
    int mw = 0;
    int mf = 0;

    always #5 Clock = ~Clock;

    compteur_decompteur_source #(.WRAP(1), .STROBE_LEN(L), .STEP(1)) u_wrap (
        .Clock(Clock), .Reset(Reset), .Inc(Inc), .Dec(Dec), .Load(Load),
        .LoadValue(LoadValue), .Compteurs(cw), .Count(countw), .Busy(busyw)
`ifdef COMPTEUR_BCD_EN
        , .Bcd(bcdw)
`endif
    );

    compteur_decompteur_source #(.WRAP(0), .STROBE_LEN(L), .STEP(1)) u_free (
        .Clock(Clock), .Reset(Reset), .Inc(Inc), .Dec(Dec), .Load(Load),
        .LoadValue(LoadValue), .Compteurs(cf), .Count(countf), .Busy(busyf)
`ifdef COMPTEUR_BCD_EN
        , .Bcd(bcdf)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sv12(input logic [11:0] x);
        return int'($signed(x));
    endfunction

    function automatic int ref_step(input int v, input int d, input bit wrap);
        int r;
        r = v + d;
        if (wrap) begin
            if (r > 999) r = r - 1000;
            else if (r < 0) r = r + 1000;
        end else begin
            if (r > 2047) r = 2047;
            if (r < -2048) r = -2048;
        end
        return r;
    endfunction

`ifdef COMPTEUR_BCD_EN
    function automatic int ref_bcd(input int v);
        if (v < 0 || v > 999) return 32'hFFF;
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction
`endif

    task automatic chk_vals(input string tag);
        chk({tag, "_wrap_val"}, sv12(cw), mw);
        chk({tag, "_free_val"}, sv12(cf), mf);
    endtask

    // kind 0=load, 1=inc, 2=dec; retrig re-raises Inc while the update is busy
    task automatic run_req(input int kind, input int val, input bit retrig, input string tag);
        int lat;
        int explat;
        lat = -1;
        if (kind == 0) begin
            mw = val;
            mf = val;
        end else begin
            mw = ref_step(mw, (kind == 1) ? 1 : -1, 1'b1);
            mf = ref_step(mf, (kind == 1) ? 1 : -1, 1'b0);
        end
        explat = (kind == 0) ? 1 : 3;
        @(negedge Clock);
        if (kind == 0) begin
            Load = 1'b1;
            LoadValue = 12'(val);
        end else if (kind == 1) Inc = 1'b1;
        else Dec = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clock);
            Load = 1'b0;
            if (busyw) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_latency"}, lat, explat);
        for (int k = 0; k <= CL + L; k++) begin
            if (k > 0) @(negedge Clock);
            if (k == 0) begin
                Inc = 1'b0;
                Dec = 1'b0;
            end
            if (k == 1 && retrig) Inc = 1'b1;
            chk_vals(tag);
            chk({tag, "_count"}, int'(countw) + int'(countf), (k >= CL && k < CL + L) ? 2 : 0);
            chk({tag, "_busy"}, int'(busyw) + int'(busyf), (k < CL + L) ? 2 : 0);
`ifdef COMPTEUR_BCD_EN
            if (k == CL) begin
                chk({tag, "_wrap_bcd"}, int'(bcdw), ref_bcd(mw));
                chk({tag, "_free_bcd"}, int'(bcdf), ref_bcd(mf));
            end
`endif
        end
        for (int k = 0; k < (retrig ? 6 : 3); k++) begin
            @(negedge Clock);
            if (retrig) begin
                chk({tag, "_dropped_busy"}, int'(busyw) + int'(busyf), 0);
                chk_vals({tag, "_dropped"});
            end
        end
        Inc = 1'b0;
        repeat (3) @(negedge Clock);
    endtask

    // Inc and Dec rising together must cancel: no update, no strobe
    task automatic run_cancel(input string tag);
        @(negedge Clock);
        Inc = 1'b1;
        Dec = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (i == 2) begin
                Inc = 1'b0;
                Dec = 1'b0;
            end
            chk({tag, "_count"}, int'(countw) + int'(countf), 0);
            chk({tag, "_busy"}, int'(busyw) + int'(busyf), 0);
            chk_vals(tag);
        end
    endtask

    initial begin
        int kind;
        int v;
        int picks [7];
        picks = '{0, 999, 1000, 2047, -2048, -1, 500};
        Reset = 1'b1;
        Inc = 1'b0;
        Dec = 1'b0;
        Load = 1'b0;
        LoadValue = '0;
        repeat (2) @(negedge Clock);
        chk_vals("reset");
        chk("reset_count", int'(countw) + int'(countf), 0);
        chk("reset_busy", int'(busyw) + int'(busyf), 0);
`ifdef COMPTEUR_BCD_EN
        chk("reset_bcd", int'(bcdw) + int'(bcdf), 0);
`endif
        Reset = 1'b0;
        repeat (3) @(negedge Clock);

        for (int n = 0; n < 3; n++) run_req(1, 0, 1'b0, "inc_seq");

        run_req(0, 999, 1'b0, "load999");
        run_req(1, 0, 1'b0, "inc_wrap");
        run_req(2, 0, 1'b0, "dec_wrap");
        run_req(0, 0, 1'b0, "load0");
        run_req(2, 0, 1'b0, "dec_neg");
        chk("dec_neg_raw", int'(cf), 32'hFFF);
        run_req(0, 2047, 1'b0, "load2047");
        run_req(1, 0, 1'b0, "inc_sat");
`ifdef COMPTEUR_BCD_EN
        run_req(0, 472, 1'b0, "load472");
        run_req(0, 1000, 1'b0, "load1000");
`endif
        run_cancel("cancel");
        run_req(0, 10, 1'b0, "load10");
        run_req(1, 0, 1'b1, "busy_drop");

        // Reset asserted while Count is high must clear it at once
        @(negedge Clock);
        Inc = 1'b1;
        for (int i = 0; i < CL + 12; i++) begin
            @(negedge Clock);
            if (countw) break;
        end
        chk("rst_strobe_seen", int'(countw), 1);
        #2;
        Reset = 1'b1;
        Inc = 1'b0;
        #1;
        mw = 0;
        mf = 0;
        chk("rst_strobe_count", int'(countw) + int'(countf), 0);
        chk("rst_strobe_busy", int'(busyw) + int'(busyf), 0);
        chk_vals("rst_strobe");
        @(negedge Clock);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 3) run_cancel("rnd_cancel");
            else begin
                if ($urandom_range(0, 1) == 0) v = picks[$urandom_range(0, 6)];
                else v = int'($urandom_range(0, 4095)) - 2048;
                run_req(kind, v, 1'b0, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
